// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Two requesters share a single external FIFO. A combinational round-robin
// arbiter picks at most one requester per cycle and pushes its word into the
// FIFO. An output stage pops the FIFO into a registered output word and
// holds it until the consumer takes it.
//
// Ports
//   clk             single clock, all state updates on the rising edge
//   rst             synchronous active-high reset; also gates all strobes
//   req0 / data0    requester 0 push request and word
//   ack0            requester 0 word accepted this cycle (combinational)
//   req1 / data1    requester 1 push request and word
//   ack1            requester 1 word accepted this cycle (combinational)
//   fifo_push       push strobe to the shared FIFO
//   fifo_push_data  word written into the FIFO (data0 when nothing is pushed)
//   fifo_full       FIFO full flag
//   fifo_pop        pop strobe to the FIFO
//   fifo_pop_data   FIFO head word, valid while fifo_empty is low
//   fifo_empty      FIFO empty flag
//   out_valid       out_data holds a word
//   out_data        registered output word
//   out_ready       consumer takes out_data this cycle
//   cnt0 / cnt1     per-requester accepted-word counters, wrapping
// ---------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,

    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,

    output logic              fifo_push,
    output logic [DATA_W-1:0] fifo_push_data,
    input  logic              fifo_full,

    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_pop_data,
    input  logic              fifo_empty,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,

    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index of the requester that won the most recent accepted cycle.
    // Reset value 1 makes requester 0 the winner of the first contention.
    logic       last;
    logic       grant1;
    logic       accept;

    out_state_t state_q;
    out_state_t state_d;

    // Pick the winner: a lone requester always wins; on contention the
    // requester that did not win last time gets the slot. grant1 is only
    // meaningful when someone is requesting.
    always_comb begin
        grant1 = 1'b0;
        if (req0 && req1) begin
            grant1 = ~last;
        end else if (req1) begin
            grant1 = 1'b1;
        end
    end

    // A word is accepted whenever anyone requests and the FIFO has room.
    // Reset forces every strobe low so nothing leaks into the FIFO while
    // it is being cleared. A refused request simply stays pending on the
    // requester side.
    always_comb begin
        accept         = ~rst & (req0 | req1) & ~fifo_full;
        ack0           = accept & ~grant1;
        ack1           = accept & grant1;
        fifo_push      = accept;
        fifo_push_data = ack1 ? data1 : data0;
    end

    // Round-robin history only moves on an accepted cycle, so a stalled
    // contention keeps its priority order until the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant1;
        end
    end

    // Per-requester accepted-word counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (ack0) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (ack1) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

    // The output register can take a new word when it is empty or when the
    // consumer is taking the current one in this same cycle, which gives one
    // word per cycle with out_ready held high.
    always_comb begin
        out_valid = (state_q == ST_HOLD);
        fifo_pop  = ~rst & ~fifo_empty & (~out_valid | out_ready);
    end

    // Output stage next-state logic: any pop lands a word in the register;
    // a consumed word with nothing behind it empties the stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (fifo_pop) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fifo_pop) begin
                    state_d = ST_HOLD;
                end else if (out_ready && fifo_empty) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word register. It only loads on a pop, so the last word stays
    // visible (but invalid) after the stage empties, and a stalled word is
    // held steady. Reset discards whatever word was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (fifo_pop) begin
            out_data <= fifo_pop_data;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_arbiter
//
// Self-checking bench for fifo_rr_arbiter. A small depth-4 FIFO model sits
// between the arbiter and the output stage; force_full can pin the full
// flag high to exercise back-pressure without filling the model.
// ---------------------------------------------------------------------------
module tb_fifo_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       fifo_push;
    logic [7:0] fifo_push_data;
    logic       fifo_full;
    logic       fifo_pop;
    logic [7:0] fifo_pop_data;
    logic       fifo_empty;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    logic       force_full;

    int checks;
    int passes;

    logic [7:0] exp_q[$];

    typedef struct {
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       ff;
        logic       e_ack0;
        logic       e_ack1;
        logic       e_push;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[16];

    fifo_rr_arbiter #(
        .DATA_W(8),
        .CNT_W (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .data0         (data0),
        .ack0          (ack0),
        .req1          (req1),
        .data1         (data1),
        .ack1          (ack1),
        .fifo_push     (fifo_push),
        .fifo_push_data(fifo_push_data),
        .fifo_full     (fifo_full),
        .fifo_pop      (fifo_pop),
        .fifo_pop_data (fifo_pop_data),
        .fifo_empty    (fifo_empty),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .cnt0          (cnt0),
        .cnt1          (cnt1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Depth-4 FIFO model, cleared by the same reset as the arbiter.
    logic [7:0] fmem [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] fcount;
    logic       push_ok;
    logic       pop_ok;

    assign fifo_full     = force_full | (fcount == 3'd4);
    assign fifo_empty    = (fcount == 3'd0);
    assign fifo_pop_data = fmem[rptr];
    assign push_ok       = fifo_push & (fcount != 3'd4);
    assign pop_ok        = fifo_pop & (fcount != 3'd0);

    // FIFO model storage and pointers.
    always @(posedge clk) begin
        if (rst) begin
            wptr   <= 2'd0;
            rptr   <= 2'd0;
            fcount <= 3'd0;
        end else begin
            if (push_ok) begin
                fmem[wptr] <= fifo_push_data;
                wptr       <= wptr + 2'd1;
            end
            if (pop_ok) begin
                rptr <= rptr + 2'd1;
            end
            fcount <= fcount + {2'b0, push_ok} - {2'b0, pop_ok};
        end
    end

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r0, input logic [7:0] d0,
                                 input logic r1, input logic [7:0] d1,
                                 input logic ff, input logic ordy);
        req0       = r0;
        data0      = d0;
        req1       = r1;
        data1      = d1;
        force_full = ff;
        out_ready  = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Every word the consumer takes must match the accept order.
    task automatic monitorOutput();
        logic [7:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL t3_extra_word: got %0h required none", out_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("t3_order", out_data, e);
            end
        end
    endtask

    // Two-cycle reset with both requests high and the consumer ready, so the
    // combinational gating is actually exercised, then the reset state check.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE, 1'b1, 8'hEF, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_ack0", 8'(ack0), 8'h00);
        checkOutput("rst_ack1", 8'(ack1), 8'h00);
        checkOutput("rst_push", 8'(fifo_push), 8'h00);
        checkOutput("rst_pop", 8'(fifo_pop), 8'h00);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rst_out_valid", 8'(out_valid), 8'h00);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_cnt0", cnt0, 8'h00);
        checkOutput("rst_cnt1", cnt1, 8'h00);
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        rst        = 1'b1;
        req0       = 1'b0;
        req1       = 1'b0;
        data0      = 8'h00;
        data1      = 8'h00;
        force_full = 1'b0;
        out_ready  = 1'b0;

        // Round-robin table, starting from reset (last=1).
        //             r0    d0     r1    d1     ff    ack0  ack1  push  data
        vecs[0]  = '{1'b1, 8'h61, 1'b1, 8'h71, 1'b0, 1'b1, 1'b0, 1'b1, 8'h61};
        vecs[1]  = '{1'b1, 8'h61, 1'b1, 8'h71, 1'b0, 1'b0, 1'b1, 1'b1, 8'h71};
        vecs[2]  = '{1'b1, 8'h62, 1'b1, 8'h72, 1'b0, 1'b1, 1'b0, 1'b1, 8'h62};
        vecs[3]  = '{1'b1, 8'h62, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 1'b1, 8'h72};
        vecs[4]  = '{1'b0, 8'h33, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
        vecs[5]  = '{1'b0, 8'h34, 1'b1, 8'h73, 1'b0, 1'b0, 1'b1, 1'b1, 8'h73};
        vecs[6]  = '{1'b0, 8'h34, 1'b1, 8'h74, 1'b0, 1'b0, 1'b1, 1'b1, 8'h74};
        vecs[7]  = '{1'b0, 8'h34, 1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 1'b1, 8'h75};
        vecs[8]  = '{1'b1, 8'h63, 1'b1, 8'h76, 1'b0, 1'b1, 1'b0, 1'b1, 8'h63};
        vecs[9]  = '{1'b1, 8'h64, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h64};
        vecs[10] = '{1'b1, 8'h65, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 1'b1, 8'h78};
        vecs[11] = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66};
        vecs[12] = '{1'b1, 8'h67, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h67};
        vecs[13] = '{1'b1, 8'h68, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h68};
        vecs[14] = '{1'b1, 8'h69, 1'b1, 8'h79, 1'b0, 1'b0, 1'b1, 1'b1, 8'h79};
        vecs[15] = '{1'b1, 8'h6A, 1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6A};

        // T1/T2: reset, then four cycles of contention with a ready consumer.
        doReset();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(c < 4, 8'h61, c < 4, 8'h71, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("t2_ack0_c%0d", c), 8'(ack0), 8'((c < 4) && (c % 2 == 0)));
            checkOutput($sformatf("t2_ack1_c%0d", c), 8'(ack1), 8'((c < 4) && (c % 2 == 1)));
            checkOutput($sformatf("t2_valid_c%0d", c), 8'(out_valid), 8'((c >= 2) && (c <= 5)));
            if (c < 2) begin
                checkOutput($sformatf("t2_data_c%0d", c), out_data, 8'h00);
            end else if (c <= 5) begin
                checkOutput($sformatf("t2_data_c%0d", c), out_data, (c % 2 == 0) ? 8'h61 : 8'h71);
            end else begin
                checkOutput($sformatf("t2_data_c%0d", c), out_data, 8'h71);
            end
            nextCycle();
        end
        checkOutput("t2_cnt0", cnt0, 8'd2);
        checkOutput("t2_cnt1", cnt1, 8'd2);

        // T3: table-driven arbitration with an ordering scoreboard.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, vecs[i].ff, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("t3_ack0_v%0d", i), 8'(ack0), 8'(vecs[i].e_ack0));
            checkOutput($sformatf("t3_ack1_v%0d", i), 8'(ack1), 8'(vecs[i].e_ack1));
            checkOutput($sformatf("t3_push_v%0d", i), 8'(fifo_push), 8'(vecs[i].e_push));
            checkOutput($sformatf("t3_pdata_v%0d", i), fifo_push_data, vecs[i].e_data);
            if (vecs[i].e_push) begin
                exp_q.push_back(vecs[i].e_data);
            end
            monitorOutput();
            nextCycle();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            monitorOutput();
            nextCycle();
        end
        checkOutput("t3_drained", 8'(exp_q.size()), 8'd0);
        checkOutput("t3_cnt0", cnt0, 8'd6);
        checkOutput("t3_cnt1", cnt1, 8'd7);

        // T4: stalled consumer, requester 0 fills the output register and FIFO.
        doReset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, 8'(8'hA0 + ((c < 5) ? c : 5)), 1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("t4_ack0_c%0d", c), 8'(ack0), 8'(c < 5));
            checkOutput($sformatf("t4_push_c%0d", c), 8'(fifo_push), 8'(c < 5));
            if (c < 5) begin
                checkOutput($sformatf("t4_pdata_c%0d", c), fifo_push_data, 8'(8'hA0 + c));
            end
            checkOutput($sformatf("t4_pop_c%0d", c), 8'(fifo_pop), 8'(c == 1));
            checkOutput($sformatf("t4_valid_c%0d", c), 8'(out_valid), 8'(c >= 2));
            if (c >= 2) begin
                checkOutput($sformatf("t4_data_c%0d", c), out_data, 8'hA0);
            end
            nextCycle();
        end
        checkOutput("t4_cnt0", cnt0, 8'd5);

        // T4b: consumer wakes up; the held request gets in once full drops.
        for (int d = 0; d < 7; d++) begin
            applyStimulus(d <= 1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            if (d <= 1) begin
                checkOutput($sformatf("t4b_ack0_d%0d", d), 8'(ack0), 8'(d == 1));
            end
            checkOutput($sformatf("t4b_valid_d%0d", d), 8'(out_valid), 8'(d <= 5));
            if (d <= 5) begin
                checkOutput($sformatf("t4b_data_d%0d", d), out_data, 8'(8'hA0 + d));
            end
            nextCycle();
        end
        checkOutput("t4b_cnt0", cnt0, 8'd6);

        // T5: reset while a word is held; history last=0 must be forgotten.
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 8'h56, 1'b0, 8'h00, 1'b0, 1'b0);
        nextCycle();
        checkOutput("t5_pre_valid", 8'(out_valid), 8'h01);
        checkOutput("t5_pre_data", out_data, 8'h55);
        doReset();
        applyStimulus(1'b1, 8'h81, 1'b1, 8'h91, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_ack0", 8'(ack0), 8'h01);
        checkOutput("t5_ack1", 8'(ack1), 8'h00);
        checkOutput("t5_pdata", fifo_push_data, 8'h81);
        nextCycle();

        // T6: counter wrap on requester 0, requester 1 count untouched.
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1);
        nextCycle();
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b1);
            nextCycle();
        end
        checkOutput("t6_cnt0_255", cnt0, 8'd255);
        applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t6_cnt0_wrap", cnt0, 8'd0);
        checkOutput("t6_cnt1", cnt1, 8'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
